// File: rtl/pwb_pkg.sv
// Shared types and helpers for the paged window bridge.
// Holds the FSM state encoding, the error fill pattern and the beat-stride helper.
// Optional window-overrun states are present only when PWB_BOUND_CHECK_EN is defined.
package pwb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_DATA,
        WR_DATA
`ifdef PWB_BOUND_CHECK_EN
        ,
        ERR_RD,
        ERR_WR
`endif
    } pwb_state_t;

    localparam logic [15:0] PWB_ERR_DATA = 16'hDEAD;

    // Byte distance between consecutive beats of a burst.
    function automatic int unsigned beat_stride(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/avmm_if.sv
// Avalon-MM signal bundle with burst support, used on both sides of the bridge.
// No logic, no latency.
// Backpressure is carried by waitrequest from slave to master.
interface avmm_if #(
    parameter int AW  = 16,
    parameter int DW  = 64,
    parameter int BCW = 1
);
    logic [AW-1:0]  address;
    logic           read;
    logic           write;
    logic [DW-1:0]  writedata;
    logic [BCW-1:0] burstcount;
    logic [DW-1:0]  readdata;
    logic           readdatavalid;
    logic           waitrequest;

    modport master (
        output address, read, write, writedata, burstcount,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, burstcount,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/pwb_beat_counter.sv
// Burst beat counter shared by the read and write paths of the bridge.
// Registered count; last is combinational from the current count.
// No backpressure of its own: it advances only when the caller pulses inc.
module pwb_beat_counter #(
    parameter int BCW = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           inc,
    input  logic [BCW-1:0] target,
    output logic           last
);

    logic [BCW-1:0] value;

    // Clear on burst capture, otherwise count accepted beats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= value + BCW'(1);
        end
    end

    assign last = (value == (target - BCW'(1)));

endmodule

// File: rtl/page_window_bridge.sv
// Maps an AW-bit host window onto a larger memory by prefixing the page latched at burst start.
// One cycle from host request to memory command; read data passes straight through, write data is combinational.
// Host waitrequest follows memory waitrequest while a burst is active and is held high in IDLE.
// Optional: PWB_BOUND_CHECK_EN rejects bursts overrunning the window and raises sticky err.
module page_window_bridge
    import pwb_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 64,
    parameter int MAX_BURST  = 1,
    parameter int PAGE_COUNT = 4,
    localparam int BCW       = $clog2(MAX_BURST) + 1,
    localparam int PCW       = $clog2(PAGE_COUNT)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [PCW-1:0] page_number,
    avmm_if.slave          bus,
    avmm_if.master         mem,
    output logic           err
);

    pwb_state_t     state_q, state_d;
    logic [AW-1:0]  addr_q;
    logic [BCW-1:0] count_q;
    logic [PCW-1:0] page_q;
    logic [BCW-1:0] count_in;
    logic           capture;
    logic           beat_inc;
    logic           beat_last;

    // A burstcount of zero is a single beat.
    assign count_in = (bus.burstcount == '0) ? BCW'(1) : bus.burstcount;

`ifdef PWB_BOUND_CHECK_EN
    localparam int SW = AW + BCW + 8;
    logic [SW-1:0] burst_end;
    logic          overrun;
    logic          err_q;

    assign burst_end = SW'(bus.address) + SW'(count_in) * SW'(beat_stride(DW));
    assign overrun   = burst_end > (SW'(1) << AW);

    // Sticky overrun flag; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (capture && overrun) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // State register and per-burst latches; page is frozen here so page changes never split a burst.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            page_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= bus.address;
                count_q <= count_in;
                page_q  <= page_number;
            end
        end
    end

    pwb_beat_counter #(
        .BCW (BCW)
    ) u_beat_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (capture),
        .inc    (beat_inc),
        .target (count_q),
        .last   (beat_last)
    );

    assign mem.address    = {page_q, addr_q};
    assign mem.burstcount = count_q;
    assign mem.writedata  = bus.writedata;

    // Next-state and handshake steering for both sides of the bridge.
    always_comb begin
        state_d           = state_q;
        capture           = 1'b0;
        beat_inc          = 1'b0;
        bus.waitrequest   = 1'b1;
        bus.readdatavalid = 1'b0;
        bus.readdata      = {DW{1'b0}};
        mem.read          = 1'b0;
        mem.write         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.write || bus.read) begin
                    capture = 1'b1;
`ifdef PWB_BOUND_CHECK_EN
                    if (overrun) begin
                        state_d = bus.write ? ERR_WR : ERR_RD;
                    end else begin
                        state_d = bus.write ? WR_DATA : RD_CMD;
                    end
`else
                    state_d = bus.write ? WR_DATA : RD_CMD;
`endif
                end
            end
            RD_CMD: begin
                mem.read        = 1'b1;
                bus.waitrequest = mem.waitrequest;
                if (!mem.waitrequest) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                bus.readdata      = mem.readdata;
                bus.readdatavalid = mem.readdatavalid;
                if (mem.readdatavalid) begin
                    beat_inc = 1'b1;
                    if (beat_last) begin
                        state_d = IDLE;
                    end
                end
            end
            WR_DATA: begin
                mem.write       = bus.write;
                bus.waitrequest = mem.waitrequest;
                if (bus.write && !mem.waitrequest) begin
                    beat_inc = 1'b1;
                    if (beat_last) begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef PWB_BOUND_CHECK_EN
            ERR_WR: begin
                bus.waitrequest = 1'b0;
                if (bus.write) begin
                    beat_inc = 1'b1;
                    if (beat_last) begin
                        state_d = IDLE;
                    end
                end
            end
            ERR_RD: begin
                bus.waitrequest   = 1'b0;
                bus.readdatavalid = 1'b1;
                bus.readdata      = DW'(PWB_ERR_DATA);
                beat_inc          = 1'b1;
                if (beat_last) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
